// File: rtl/ecc_pkg.sv
// Shared widths, helpers and flag type for the SECDED stream decoder.
package ecc_pkg;

  function automatic int parity_width(input int data_width);
    int p;
    p = 0;
    while ((1 << p) < data_width + p + 1) p++;
    return p;
  endfunction

  function automatic int code_width(input int data_width);
    return data_width + parity_width(data_width);
  endfunction

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  typedef struct packed {
    logic single;
    logic parity;
    logic dbl;
  } ecc_flags_t;

endpackage

// File: rtl/ecc_decode.sv
// Combinational single-lane SECDED decoder: syndrome, flags and corrected data.
module ecc_decode
  import ecc_pkg::*;
#(
  parameter int DataWidth = 64,
  localparam int P = parity_width(DataWidth),
  localparam int CW = DataWidth + P
) (
  input  logic [CW:0]          enc_i,
  output logic [DataWidth-1:0] data_o,
  output logic [P-1:0]         syndrome_o,
  output ecc_flags_t           flags_o
);

  typedef struct packed {
    logic          parity;
    logic [CW-1:0] code_word;
  } lane_enc_t;

  function automatic logic [DataWidth-1:0] extract(input logic [CW-1:0] cw);
    logic [DataWidth-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int j = 0; j < CW; j++) begin
      if (((j + 1) & j) != 0) begin
        d[k] = cw[j];
        k++;
      end
    end
    return d;
  endfunction

  lane_enc_t     enc;
  logic [P-1:0]  syn;
  logic          parity_bad;
  logic [CW-1:0] corr;

  always_comb begin
    enc = enc_i;
    syn = '0;
    for (int i = 0; i < P; i++) begin
      for (int j = 0; j < CW; j++) begin
        if ((((j + 1) >> i) & 1) != 0) syn[i] = syn[i] ^ enc.code_word[j];
      end
    end
    parity_bad = enc.parity ^ (^enc.code_word);
    flags_o.single = parity_bad & (|syn);
    flags_o.parity = parity_bad & ~(|syn);
    flags_o.dbl    = ~parity_bad & (|syn);
    // Syndromes beyond the code word never match a position, so no flip happens.
    corr = enc.code_word;
    for (int j = 0; j < CW; j++) begin
      if (syn == P'(j + 1)) corr[j] = ~corr[j];
    end
    data_o     = extract(corr);
    syndrome_o = syn;
  end

endmodule

// File: rtl/ecc_decode_stream.sv
// Multi-lane pipelined SECDED decoder with valid/ready stream, error counters and capture.
module ecc_decode_stream
  import ecc_pkg::*;
#(
  parameter int DataWidth = 64,
  parameter int NumLanes  = 4,
  parameter int NumStages = 2,
  parameter int TagWidth  = 8,
  parameter int CntWidth  = 16,
  localparam int P     = parity_width(DataWidth),
  localparam int CW    = DataWidth + P,
  localparam int EW    = CW + 1,
  localparam int LaneW = clog2_min1(NumLanes)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          correct_en_i,
  input  logic                          clear_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [NumLanes*EW-1:0]        data_i,
  input  logic [TagWidth-1:0]           tag_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [NumLanes*DataWidth-1:0] data_o,
  output logic [TagWidth-1:0]           tag_o,
  output logic [NumLanes-1:0]           single_error_o,
  output logic [NumLanes-1:0]           parity_error_o,
  output logic [NumLanes-1:0]           double_error_o,
  output logic [CntWidth-1:0]           single_cnt_o,
  output logic [CntWidth-1:0]           parity_cnt_o,
  output logic [CntWidth-1:0]           double_cnt_o,
  output logic                          err_valid_o,
  output logic [LaneW-1:0]              err_lane_o,
  output logic [P-1:0]                  err_syndrome_o,
  output logic [TagWidth-1:0]           err_tag_o
);

  function automatic logic [DataWidth-1:0] extract(input logic [CW-1:0] cw);
    logic [DataWidth-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int j = 0; j < CW; j++) begin
      if (((j + 1) & j) != 0) begin
        d[k] = cw[j];
        k++;
      end
    end
    return d;
  endfunction

  function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] a,
                                                  input logic [CntWidth-1:0] b);
    logic [CntWidth:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CntWidth] ? '1 : s[CntWidth-1:0];
  endfunction

  function automatic logic [CntWidth-1:0] popcnt(input logic [NumLanes-1:0] v);
    logic [CntWidth-1:0] r;
    r = '0;
    for (int i = 0; i < NumLanes; i++) begin
      if (v[i]) r = sat_add(r, CntWidth'(1));
    end
    return r;
  endfunction

  logic                   vld_p0;
  logic [NumLanes*EW-1:0] data_p0;
  logic [TagWidth-1:0]    tag_p0;
  logic                   vld_p1;
  logic                   ready_p1;

  assign ready_p1 = ~vld_p1 | ready_i;

  // ---- stage p0: optional input register ----
  if (NumStages >= 2) begin : g_in_stage
    assign ready_o = ~vld_p0 | ready_p1;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)        vld_p0 <= 1'b0;
      else if (ready_o) vld_p0 <= valid_i;
    end

    always_ff @(posedge clk_i) begin
      if (valid_i && ready_o) begin
        data_p0 <= data_i;
        tag_p0  <= tag_i;
      end
    end
  end else begin : g_no_in_stage
    assign ready_o = ready_p1;
    assign vld_p0  = valid_i;
    assign data_p0 = data_i;
    assign tag_p0  = tag_i;
  end

  ecc_flags_t           dec_flags [NumLanes];
  logic [DataWidth-1:0] dec_corr  [NumLanes];
  logic [DataWidth-1:0] dec_out   [NumLanes];
  logic [P-1:0]         dec_syn   [NumLanes];

  for (genvar l = 0; l < NumLanes; l++) begin : g_lane
    ecc_decode #(.DataWidth(DataWidth)) u_dec (
      .enc_i      (data_p0[l*EW +: EW]),
      .data_o     (dec_corr[l]),
      .syndrome_o (dec_syn[l]),
      .flags_o    (dec_flags[l])
    );
    assign dec_out[l] = correct_en_i ? dec_corr[l] : extract(data_p0[l*EW +: CW]);
  end

  // ---- stage p1: decode result registered with its flags ----
  logic [NumLanes*DataWidth-1:0] data_p1;
  logic [TagWidth-1:0]           tag_p1;
  logic [NumLanes-1:0]           single_p1, parity_p1, double_p1;
  logic [P-1:0]                  syn_p1 [NumLanes];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1    <= 1'b0;
      data_p1   <= '0;
      tag_p1    <= '0;
      single_p1 <= '0;
      parity_p1 <= '0;
      double_p1 <= '0;
      for (int l = 0; l < NumLanes; l++) syn_p1[l] <= '0;
    end else if (ready_p1) begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        tag_p1 <= tag_p0;
        for (int l = 0; l < NumLanes; l++) begin
          data_p1[l*DataWidth +: DataWidth] <= dec_out[l];
          single_p1[l] <= dec_flags[l].single;
          parity_p1[l] <= dec_flags[l].parity;
          double_p1[l] <= dec_flags[l].dbl;
          syn_p1[l]    <= dec_syn[l];
        end
      end
    end
  end

  assign valid_o        = vld_p1;
  assign data_o         = data_p1;
  assign tag_o          = tag_p1;
  assign single_error_o = single_p1;
  assign parity_error_o = parity_p1;
  assign double_error_o = double_p1;

  logic                handshake;
  logic [CntWidth-1:0] single_inc, parity_inc, double_inc;
  logic [CntWidth-1:0] single_cnt, parity_cnt, double_cnt;
  logic [LaneW-1:0]    cap_lane;
  logic [P-1:0]        cap_syn;

  assign handshake = vld_p1 & ready_i;

  always_comb begin
    single_inc = handshake ? popcnt(single_p1) : '0;
    parity_inc = handshake ? popcnt(parity_p1) : '0;
    double_inc = handshake ? popcnt(double_p1) : '0;
    cap_lane   = '0;
    cap_syn    = '0;
    for (int l = NumLanes - 1; l >= 0; l--) begin
      if (double_p1[l]) begin
        cap_lane = LaneW'(l);
        cap_syn  = syn_p1[l];
      end
    end
  end

  // Clear zeroes the base first so the same-cycle handshake still counts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      single_cnt <= '0;
      parity_cnt <= '0;
      double_cnt <= '0;
    end else begin
      single_cnt <= sat_add(clear_i ? '0 : single_cnt, single_inc);
      parity_cnt <= sat_add(clear_i ? '0 : parity_cnt, parity_inc);
      double_cnt <= sat_add(clear_i ? '0 : double_cnt, double_inc);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_valid_o    <= 1'b0;
      err_lane_o     <= '0;
      err_syndrome_o <= '0;
      err_tag_o      <= '0;
    end else begin
      if (clear_i) begin
        err_valid_o    <= 1'b0;
        err_lane_o     <= '0;
        err_syndrome_o <= '0;
        err_tag_o      <= '0;
      end
      if (handshake && (|double_p1) && (clear_i || !err_valid_o)) begin
        err_valid_o    <= 1'b1;
        err_lane_o     <= cap_lane;
        err_syndrome_o <= cap_syn;
        err_tag_o      <= tag_p1;
      end
    end
  end

  assign single_cnt_o = single_cnt;
  assign parity_cnt_o = parity_cnt;
  assign double_cnt_o = double_cnt;

endmodule

// File: tb/tb_ecc_decode_stream.sv
// Bench for ecc_decode_stream: DataWidth=8, two lanes, two stages, 16-bit and 2-bit counters.
module tb_ecc_decode_stream;

  localparam int EW = 13;

  logic        clk = 1'b0;
  logic        rst_i, correct_en_i, clear_i, valid_i, ready_i;
  logic [25:0] data_i;
  logic [7:0]  tag_i;

  logic        ready_o, valid_o, err_valid_o, err_lane_o;
  logic [15:0] data_o, single_cnt_o, parity_cnt_o, double_cnt_o;
  logic [7:0]  tag_o, err_tag_o;
  logic [1:0]  single_error_o, parity_error_o, double_error_o;
  logic [3:0]  err_syndrome_o;

  logic        b_ready_o, b_valid_o, b_err_valid_o, b_err_lane_o;
  logic [15:0] b_data_o;
  logic [1:0]  b_single_cnt_o, b_parity_cnt_o, b_double_cnt_o;
  logic [7:0]  b_tag_o, b_err_tag_o;
  logic [1:0]  b_single_error_o, b_parity_error_o, b_double_error_o;
  logic [3:0]  b_err_syndrome_o;

  ecc_decode_stream #(.DataWidth(8), .NumLanes(2), .NumStages(2), .TagWidth(8), .CntWidth(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .correct_en_i(correct_en_i), .clear_i(clear_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .tag_i(tag_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .tag_o(tag_o),
    .single_error_o(single_error_o), .parity_error_o(parity_error_o), .double_error_o(double_error_o),
    .single_cnt_o(single_cnt_o), .parity_cnt_o(parity_cnt_o), .double_cnt_o(double_cnt_o),
    .err_valid_o(err_valid_o), .err_lane_o(err_lane_o), .err_syndrome_o(err_syndrome_o), .err_tag_o(err_tag_o)
  );

  ecc_decode_stream #(.DataWidth(8), .NumLanes(2), .NumStages(2), .TagWidth(8), .CntWidth(2)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .correct_en_i(correct_en_i), .clear_i(clear_i),
    .valid_i(valid_i), .ready_o(b_ready_o), .data_i(data_i), .tag_i(tag_i),
    .valid_o(b_valid_o), .ready_i(ready_i), .data_o(b_data_o), .tag_o(b_tag_o),
    .single_error_o(b_single_error_o), .parity_error_o(b_parity_error_o), .double_error_o(b_double_error_o),
    .single_cnt_o(b_single_cnt_o), .parity_cnt_o(b_parity_cnt_o), .double_cnt_o(b_double_cnt_o),
    .err_valid_o(b_err_valid_o), .err_lane_o(b_err_lane_o), .err_syndrome_o(b_err_syndrome_o), .err_tag_o(b_err_tag_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hamming encode: data at non-power-of-two positions, check bits chosen to zero the index XOR.
  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [11:0] cw;
    logic [3:0]  s;
    int k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = d[k];
        k++;
      end
    end
    s = '0;
    for (int pos = 1; pos <= 12; pos++) if (cw[pos-1]) s = s ^ 4'(pos);
    for (int i = 0; i < 4; i++) cw[(1 << i) - 1] = s[i];
    return {^cw, cw};
  endfunction

  // Reference decode: syndrome is the XOR of the 1-based positions of all set bits.
  task automatic model_lane(input logic [12:0] enc, input logic ce, output logic [7:0] d,
                            output logic [2:0] f, output logic [3:0] syn);
    logic [11:0] cw;
    logic        par;
    int k;
    syn = '0;
    for (int pos = 1; pos <= 12; pos++) if (enc[pos-1]) syn = syn ^ 4'(pos);
    par = ^enc;
    f   = {par && syn != 0, par && syn == 0, !par && syn != 0};
    cw  = enc[11:0];
    if (ce && syn != 0 && syn <= 12) cw[syn-1] = ~cw[syn-1];
    d = '0;
    k = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = cw[pos-1];
        k++;
      end
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  typedef struct packed {
    logic [25:0] data;
    logic [7:0]  tag;
    logic        ce;
  } beat_t;

  beat_t q[$];
  int    m_single, m_parity, m_double, mb_single, mb_parity, mb_double;
  logic  m_ev, m_lane;
  logic [3:0]  m_syn;
  logic [7:0]  m_tag;
  logic        prev_stall;
  logic [15:0] prev_data;
  logic [7:0]  prev_tag;

  always @(negedge clk) begin
    logic [7:0]  d0, d1;
    logic [2:0]  f0, f1;
    logic [3:0]  s0, s1;
    logic [15:0] exp_d;
    logic [1:0]  es, ep, ed;
    beat_t       b;
    if (rst_i) begin
      q.delete();
      m_single = 0; m_parity = 0; m_double = 0;
      mb_single = 0; mb_parity = 0; mb_double = 0;
      m_ev = 1'b0; m_lane = 1'b0; m_syn = '0; m_tag = '0;
      prev_stall = 1'b0;
    end else begin
      check("single_cnt", single_cnt_o, 64'(m_single));
      check("parity_cnt", parity_cnt_o, 64'(m_parity));
      check("double_cnt", double_cnt_o, 64'(m_double));
      check("b_single_cnt", b_single_cnt_o, 64'(mb_single));
      check("b_parity_cnt", b_parity_cnt_o, 64'(mb_parity));
      check("b_double_cnt", b_double_cnt_o, 64'(mb_double));
      check("err_valid", err_valid_o, m_ev);
      check("err_lane", err_lane_o, m_lane);
      check("err_syndrome", err_syndrome_o, m_syn);
      check("err_tag", err_tag_o, m_tag);
      check("b_err_valid", b_err_valid_o, m_ev);
      if (prev_stall) begin
        check("stall_data_stable", data_o, prev_data);
        check("stall_tag_stable", tag_o, prev_tag);
        check("stall_valid_held", valid_o, 1'b1);
      end
      if (valid_o) begin
        check("beat_expected", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          model_lane(q[0].data[12:0], q[0].ce, d0, f0, s0);
          model_lane(q[0].data[25:13], q[0].ce, d1, f1, s1);
          check("data_o", data_o, {d1, d0});
          check("b_data_o", b_data_o, {d1, d0});
          check("tag_o", tag_o, q[0].tag);
          check("single_error_o", single_error_o, {f1[2], f0[2]});
          check("parity_error_o", parity_error_o, {f1[1], f0[1]});
          check("double_error_o", double_error_o, {f1[0], f0[0]});
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
      prev_tag   = tag_o;
      if (clear_i) begin
        m_single = 0; m_parity = 0; m_double = 0;
        mb_single = 0; mb_parity = 0; mb_double = 0;
        m_ev = 1'b0; m_lane = 1'b0; m_syn = '0; m_tag = '0;
      end
      if (valid_o && ready_i && q.size() != 0) begin
        b = q.pop_front();
        model_lane(b.data[12:0], b.ce, d0, f0, s0);
        model_lane(b.data[25:13], b.ce, d1, f1, s1);
        m_single  = sat(m_single + int'(f0[2]) + int'(f1[2]), 65535);
        m_parity  = sat(m_parity + int'(f0[1]) + int'(f1[1]), 65535);
        m_double  = sat(m_double + int'(f0[0]) + int'(f1[0]), 65535);
        mb_single = sat(mb_single + int'(f0[2]) + int'(f1[2]), 3);
        mb_parity = sat(mb_parity + int'(f0[1]) + int'(f1[1]), 3);
        mb_double = sat(mb_double + int'(f0[0]) + int'(f1[0]), 3);
        if (!m_ev && (f0[0] || f1[0])) begin
          m_ev   = 1'b1;
          m_lane = f0[0] ? 1'b0 : 1'b1;
          m_syn  = f0[0] ? s0 : s1;
          m_tag  = b.tag;
        end
      end
      if (valid_i && ready_o) q.push_back('{data: data_i, tag: tag_i, ce: correct_en_i});
    end
  end

  task automatic send(input logic [12:0] l0, input logic [12:0] l1, input logic [7:0] tag);
    logic ok;
    ok      = 1'b0;
    data_i  = {l1, l0};
    tag_i   = tag;
    valid_i = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = ready_o;
      @(posedge clk);
    end
    #1 valid_i = 1'b0;
    check("send_handshake", ok, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (q.size() == 0) break;
    end
    #1;
    check("drain", q.size() == 0, 1'b1);
  endtask

  logic [12:0] ea5, e3c, dbl0, dbl1;

  initial begin
    rst_i = 1'b1; correct_en_i = 1'b1; clear_i = 1'b0;
    valid_i = 1'b0; ready_i = 1'b1; data_i = '0; tag_i = '0;
    ea5 = encode(8'hA5);
    e3c = encode(8'h3C);
    #2;
    check("rst_valid_o", valid_o, 1'b0);
    check("rst_data_o", data_o, 16'h0);
    check("rst_flags", {single_error_o, parity_error_o, double_error_o}, 6'h0);
    check("rst_cnt", {single_cnt_o, parity_cnt_o, double_cnt_o}, 48'h0);
    check("rst_capture", {err_valid_o, err_lane_o, err_syndrome_o, err_tag_o}, 14'h0);
    check("model_encode_a5", ea5, 13'h0A27);
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    check("ready_after_reset", ready_o, 1'b1);

    // clean words: two-cycle latency, no flags
    send(ea5, e3c, 8'h01);
    check("latency_not_early", valid_o, 1'b0);
    @(posedge clk); #1;
    check("latency_valid", valid_o, 1'b1);
    check("clean_data", data_o, 16'h3CA5);
    check("clean_flags", {single_error_o, parity_error_o, double_error_o}, 6'h0);
    drain();
    check("clean_cnt", single_cnt_o, 16'd0);

    // single error at code-word bit 2
    send(ea5 ^ 13'h004, e3c, 8'h02);
    @(posedge clk); #1;
    check("single_corrected", data_o[7:0], 8'hA5);
    check("single_flag", single_error_o, 2'b01);
    @(posedge clk); #1;
    check("single_cnt_1", single_cnt_o, 16'd1);
    drain();
    correct_en_i = 1'b0;
    send(ea5 ^ 13'h004, e3c, 8'h03);
    @(posedge clk); #1;
    check("single_uncorrected", data_o[7:0], 8'hA4);
    check("single_flag_nocorr", single_error_o, 2'b01);
    drain();
    correct_en_i = 1'b1;

    // overall parity bit of lane 1
    send(ea5, e3c ^ 13'h1000, 8'h04);
    @(posedge clk); #1;
    check("parity_flag", parity_error_o, 2'b10);
    check("parity_data", data_o[15:8], 8'h3C);
    @(posedge clk); #1;
    check("parity_cnt_1", parity_cnt_o, 16'd1);
    drain();

    // double errors in both lanes, capture must stick to the first
    dbl0 = ea5 ^ 13'h014;
    dbl1 = e3c ^ 13'h003;
    send(dbl0, dbl1, 8'h5A);
    send(dbl0, dbl1, 8'h77);
    check("double_flag", double_error_o, 2'b11);
    check("double_tag", tag_o, 8'h5A);
    @(posedge clk); #1;
    check("double_cnt_2", double_cnt_o, 16'd2);
    check("cap_valid", err_valid_o, 1'b1);
    check("cap_lane", err_lane_o, 1'b0);
    check("cap_syn", err_syndrome_o, 4'h6);
    check("cap_tag", err_tag_o, 8'h5A);
    @(posedge clk); #1;
    check("double_cnt_4", double_cnt_o, 16'd4);
    check("cap_tag_kept", err_tag_o, 8'h5A);
    drain();

    // back-to-back singles with a 3-cycle output stall
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(encode(8'(i * 37 + 1)) ^ (13'h1 << (i % 12)),
               encode(8'(i * 91 + 7)) ^ (13'h1 << ((i + 5) % 12)), 8'(8'h10 + i));
      end
      begin
        repeat (3) @(posedge clk);
        #1 ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    drain();
    check("stream_single_cnt", single_cnt_o, 16'd18);

    // saturation on the 2-bit instance, then clear with a same-cycle handshake
    @(posedge clk); #1 clear_i = 1'b1;
    @(posedge clk); #1 clear_i = 1'b0;
    check("clear_cnt", single_cnt_o, 16'd0);
    check("clear_cap", err_valid_o, 1'b0);
    for (int i = 0; i < 5; i++) send(encode(8'(i + 3)) ^ 13'h020, encode(8'(i)), 8'(8'h40 + i));
    drain();
    check("b_sat", b_single_cnt_o, 2'd3);
    check("a_nosat", single_cnt_o, 16'd5);
    send(ea5 ^ 13'h100, e3c, 8'h50);
    @(posedge clk); #1;
    check("clear_hs_valid", valid_o, 1'b1);
    clear_i = 1'b1;
    @(posedge clk); #1 clear_i = 1'b0;
    check("b_clear_plus_one", b_single_cnt_o, 2'd1);
    check("a_clear_plus_one", single_cnt_o, 16'd1);

    // asynchronous reset with beats in flight
    send(ea5 ^ 13'h001, e3c, 8'h61);
    send(ea5, e3c ^ 13'h800, 8'h62);
    #1 rst_i = 1'b1;
    #1;
    check("arst_valid_o", valid_o, 1'b0);
    check("arst_data_o", data_o, 16'h0);
    check("arst_tag_o", tag_o, 8'h0);
    check("arst_flags", {single_error_o, parity_error_o, double_error_o}, 6'h0);
    check("arst_single_cnt", single_cnt_o, 16'd0);
    check("arst_b_single_cnt", b_single_cnt_o, 2'd0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    check("arst_ready", ready_o, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("arst_no_ghost", valid_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
